// File: rtl/bu_diag_seq.sv
// Operand sequencer and result collector for the pipelined (a-b)^2 unit.
// Streams L operand pairs from the operand RAMs and writes results back in arrival order.
module bu_diag_seq #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 32
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data_a,
    input  logic [31:0]       rd_data_b,
    output logic [31:0]       data_a_sum,
    output logic [31:0]       data_b_sum,
    output logic              data_in_flag,
    input  logic [31:0]       result_in,
    input  logic              data_available,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [ADDR_W:0]   MAX_LEN  = (ADDR_W + 1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [WD_W-1:0]   WD_ONE   = WD_W'(1);
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   collect_q, collect_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              flag_q, flag_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              collecting;

    assign collecting = (state_q == S_ISSUE) || (state_q == S_DRAIN);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        collect_d  = collect_q;
        wd_d       = wd_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_valid_d = rd_en_q;
        flag_d     = rd_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        err_d      = err_q;

        // RAM data arrives one cycle after the read; register it onto the unit inputs.
        if (rd_valid_q) begin
            a_d = rd_data_a;
            b_d = rd_data_b;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d     = (length > MAX_LEN) ? MAX_LEN : length;
                    err_d     = 1'b0;
                    collect_d = '0;
                    wd_d      = '0;
                    rd_addr_d = '0;
                    if (len_d == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ISSUE;
                        rd_en_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if ({1'b0, rd_addr_q} == len_q - CNT_ONE) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_ONE;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        // Results outside a run, or beyond the L-th, are dropped and flagged.
        if (data_available) begin
            if (collecting && (collect_q < len_q)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = collect_q[ADDR_W-1:0];
                wr_data_d = result_in;
                collect_d = collect_q + CNT_ONE;
            end else begin
                err_d = 1'b1;
            end
        end

        if (state_q == S_DRAIN) begin
            wd_d = data_available ? '0 : wd_q + WD_ONE;
            if (collect_d == len_q) begin
                state_d = S_FIN;
            end else if (wd_d == WD_LIMIT) begin
                err_d   = 1'b1;
                state_d = S_FIN;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            collect_q  <= '0;
            wd_q       <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            flag_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            collect_q  <= collect_d;
            wd_q       <= wd_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            rd_valid_q <= rd_valid_d;
            flag_q     <= flag_d;
            a_q        <= a_d;
            b_q        <= b_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign data_a_sum   = a_q;
    assign data_b_sum   = b_q;
    assign data_in_flag = flag_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_bu_diag_seq.sv
// Bench for bu_diag_seq: operand RAM model, latency-23 (a-b)^2 unit model and a write scoreboard.
module tb_bu_diag_seq;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 32;
    localparam int LAT     = 23;
    localparam int DEPTH   = 16;

    logic              clock = 1'b0;
    logic              aclr;
    logic              start;
    logic [ADDR_W:0]   length;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data_a, rd_data_b;
    logic [31:0]       data_a_sum, data_b_sum;
    logic              data_in_flag;
    logic [31:0]       result_in;
    logic              data_available;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy, done, err;

    logic              stray_dav;
    logic [31:0]       stray_data;
    int                drop_idx;

    int checks = 0;
    int errors = 0;

    bu_diag_seq #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .aclr(aclr), .start(start), .length(length),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .data_a_sum(data_a_sum), .data_b_sum(data_b_sum), .data_in_flag(data_in_flag),
        .result_in(result_in), .data_available(data_available),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    // Single-precision helpers, valid for zero and normal numbers only.
    function automatic real f32_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] sq_diff(input logic [31:0] a, input logic [31:0] b);
        real diff;
        diff = f32_to_real(a) - f32_to_real(b);
        return real_to_f32(diff * diff);
    endfunction

    logic [31:0] ram_a [DEPTH];
    logic [31:0] ram_b [DEPTH];

    always @(posedge clock) begin
        if (rd_en) begin
            rd_data_a <= ram_a[rd_addr];
            rd_data_b <= ram_b[rd_addr];
        end
    end

    // Unit model: fixed latency, optionally swallowing one result of the run.
    logic [LAT-1:0] pipe_v;
    logic [31:0]    pipe_d [LAT];
    int             unit_cnt;

    always @(posedge clock or posedge aclr) begin
        if (aclr) begin
            pipe_v   <= '0;
            unit_cnt <= 0;
        end else begin
            pipe_v <= {pipe_v[LAT-2:0], data_in_flag && (unit_cnt != drop_idx)};
            for (int i = LAT - 1; i > 0; i--) pipe_d[i] <= pipe_d[i-1];
            pipe_d[0] <= sq_diff(data_a_sum, data_b_sum);
            if (start && !busy) unit_cnt <= 0;
            else if (data_in_flag) unit_cnt <= unit_cnt + 1;
        end
    end

    assign data_available = pipe_v[LAT-1] | stray_dav;
    assign result_in      = pipe_v[LAT-1] ? pipe_d[LAT-1] : stray_data;

    typedef struct {
        int length;
        int exp_n;
        bit drop_last;
        bit exp_err;
        int poke_cyc;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t  sb[$];
    vec_t vecs[7];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        int  eff, n_rd, n_flag, n_wr, n_done, first_flag, last_flag, last_wr, done_cyc, cyc, post;
        wr_t e;
        eff = (v.length > DEPTH) ? DEPTH : v.length;
        sb.delete();
        for (int i = 0; i < v.exp_n; i++)
            sb.push_back('{addr: ADDR_W'(i), data: sq_diff(ram_a[i], ram_b[i])});
        drop_idx = v.drop_last ? eff - 1 : -1;
        n_rd = 0; n_flag = 0; n_wr = 0; n_done = 0;
        first_flag = -1; last_flag = -1; last_wr = -1; done_cyc = -1;
        cyc = 0; post = 0;
        @(negedge clock);
        start  = 1'b1;
        length = (ADDR_W + 1)'(v.length);
        while (post <= 3 && cyc <= 400) begin
            @(negedge clock);
            start = 1'b0;
            cyc++;
            if (v.poke_cyc != 0 && cyc == v.poke_cyc) begin
                start  = 1'b1;
                length = (ADDR_W + 1)'(2);
            end
            if (cyc == 1) check_output("err_cleared_on_start", err, 0);
            if (rd_en) n_rd++;
            if (data_in_flag) begin
                if (n_flag < DEPTH) begin
                    check_output("data_a_sum", data_a_sum, ram_a[n_flag]);
                    check_output("data_b_sum", data_b_sum, ram_b[n_flag]);
                end
                if (first_flag < 0) first_flag = cyc;
                last_flag = cyc;
                n_flag++;
            end
            if (wr_en) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_write", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_output("wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
                    check_output("wr_data", wr_data, e.data);
                end
                if (v.length == 1 && n_wr == 0) check_output("single_result", wr_data, 32'h40800000);
                n_wr++;
                last_wr = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (n_done > 0) post++;
        end
        check_output("read_count", n_rd, eff);
        check_output("flag_count", n_flag, eff);
        check_output("write_count", n_wr, v.exp_n);
        check_output("scoreboard_left", sb.size(), 0);
        check_output("done_count", n_done, 1);
        check_output("err_final", err, v.exp_err);
        check_output("busy_after", busy, 0);
        if (eff > 0) begin
            check_output("first_flag_cycle", first_flag, 3);
            check_output("flag_contiguous", last_flag - first_flag + 1, eff);
            check_output("done_after_write", done_cyc - last_wr, v.drop_last ? TIMEOUT + 1 : 1);
        end else begin
            check_output("done_zero_len", done_cyc, 2);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_rd_en"}, rd_en, 0);
        check_output({tag, "_rd_addr"}, {28'd0, rd_addr}, 0);
        check_output({tag, "_flag"}, data_in_flag, 0);
        check_output({tag, "_a_sum"}, data_a_sum, 0);
        check_output({tag, "_b_sum"}, data_b_sum, 0);
        check_output({tag, "_wr_en"}, wr_en, 0);
        check_output({tag, "_wr_data"}, wr_data, 0);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_done"}, done, 0);
        check_output({tag, "_err"}, err, 0);
    endtask

    initial begin
        bit found;
        aclr       = 1'b1;
        start      = 1'b0;
        length     = '0;
        stray_dav  = 1'b0;
        stray_data = '0;
        drop_idx   = -1;
        for (int i = 0; i < DEPTH; i++) begin
            ram_a[i] = real_to_f32(real'(i + 3));
            ram_b[i] = real_to_f32(real'((i % 4) + 1));
        end

        vecs[0] = '{length: 1,  exp_n: 1,  drop_last: 0, exp_err: 0, poke_cyc: 0};
        vecs[1] = '{length: 16, exp_n: 16, drop_last: 0, exp_err: 0, poke_cyc: 0};
        vecs[2] = '{length: 0,  exp_n: 0,  drop_last: 0, exp_err: 0, poke_cyc: 0};
        vecs[3] = '{length: 20, exp_n: 16, drop_last: 0, exp_err: 0, poke_cyc: 0};
        vecs[4] = '{length: 4,  exp_n: 3,  drop_last: 1, exp_err: 1, poke_cyc: 0};
        vecs[5] = '{length: 3,  exp_n: 3,  drop_last: 0, exp_err: 0, poke_cyc: 0};
        vecs[6] = '{length: 8,  exp_n: 8,  drop_last: 0, exp_err: 0, poke_cyc: 4};

        repeat (3) @(negedge clock);
        check_all_zero("reset");
        aclr = 1'b0;
        repeat (2) @(negedge clock);

        for (int k = 0; k < 7; k++) begin
            $display("[TB] vector %0d length=%0d", k, vecs[k].length);
            apply_stimulus(vecs[k]);
        end

        $display("[TB] stray data_available in IDLE");
        @(negedge clock);
        stray_dav  = 1'b1;
        stray_data = 32'hDEADBEEF;
        @(negedge clock);
        stray_dav = 1'b0;
        check_output("stray_no_write", wr_en, 0);
        @(negedge clock);
        check_output("stray_no_write_2", wr_en, 0);
        check_output("stray_err", err, 1);
        check_output("stray_busy", busy, 0);
        apply_stimulus('{length: 2, exp_n: 2, drop_last: 0, exp_err: 0, poke_cyc: 0});

        $display("[TB] reset during ISSUE");
        drop_idx = -1;
        found    = 1'b0;
        @(negedge clock);
        start  = 1'b1;
        length = (ADDR_W + 1)'(10);
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (rd_en && rd_addr == 4'd5) found = 1'b1;
        end
        check_output("reached_element5", found, 1);
        #1 aclr = 1'b1;
        #1 check_all_zero("midrun_reset");
        @(negedge clock);
        aclr = 1'b0;
        repeat (2) @(negedge clock);
        apply_stimulus('{length: 3, exp_n: 3, drop_last: 0, exp_err: 0, poke_cyc: 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bu_diag_seq.md
Name: bu_diag_seq

Overview:
- Operand sequencer and result collector for the pipelined square-of-difference unit, which computes (a-b)^2 with fixed latency.
- Reads L operand pairs from two synchronous operand RAMs and streams them into the unit with data_in_flag.
- Captures each result flagged by data_available into a result RAM, in issue order.
- Signals completion to the UKF control FSM.

Parameters:
ADDR_W, 4, address width of the operand and result RAMs; maximum vector length is 2^ADDR_W.
TIMEOUT, 32, number of consecutive cycles in DRAIN with no data_available before an error abort (must exceed the unit latency of 23).

Ports:
clock  in  1  system clock, rising edge.
aclr  in  1  asynchronous active-high reset.
start  in  1  one-cycle request to run; sampled only in IDLE.
length  in  ADDR_W+1  element count L; values above 2^ADDR_W are clamped to 2^ADDR_W.
rd_en  out  1  operand RAM read enable.
rd_addr  out  ADDR_W  operand RAM address.
rd_data_a  in  32  operand A; valid one cycle after rd_en.
rd_data_b  in  32  operand B; valid one cycle after rd_en.
data_a_sum  out  32  operand A to the unit.
data_b_sum  out  32  operand B to the unit.
data_in_flag  out  1  operand pair valid this cycle.
result_in  in  32  result from the unit.
data_available  in  1  result_in valid this cycle.
wr_en  out  1  result RAM write enable.
wr_addr  out  ADDR_W  result RAM address.
wr_data  out  32  result RAM data.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle completion pulse.
err  out  1  sticky error flag; cleared on an accepted start.

Behaviour:
- Reset: aclr high forces all outputs, counters and registers to 0 and the FSM to IDLE, asynchronously. This applies mid-run; a partially written result RAM is not cleaned up.
- All outputs are registered.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - start=1 latches L = min(length, 2^ADDR_W), clears err, clears the issue and collect counters.
  - If L=0, go to FIN (no reads, no writes); otherwise go to ISSUE.
  - start in any other state is ignored.
- ISSUE:
  - If start is accepted at edge T, rd_en=1 with rd_addr=0,1,...,L-1 during cycles T+1..T+L.
  - Each read's data is registered onto data_a_sum/data_b_sum with data_in_flag=1 one cycle after the data is valid. data_in_flag is therefore high for exactly L consecutive cycles, T+3..T+L+2, with pairs in address order.
  - Leave ISSUE after the last rd_en. The final flag issues while in DRAIN; outstanding pipeline stages continue to be handled.
- Idle values: data_in_flag=0 and rd_en=0 outside the issue window. data_a_sum/data_b_sum hold their last value.
- Collection (ISSUE or DRAIN):
  - Each cycle with data_available=1 registers wr_en=1, wr_addr=collect count, wr_data=result_in on the next edge, then increments the collect count.
  - Results map to addresses strictly in arrival order.
- DRAIN:
  - A watchdog counter resets on every data_available and increments otherwise.
  - If collect count reaches L (including the final write), go to FIN.
  - If the watchdog reaches TIMEOUT, set err and go to FIN.
- FIN: done=1 for one cycle, then go to IDLE. busy=0 from the IDLE cycle onward.
- Stray data_available:
  - In IDLE or FIN: ignored (no write), err set.
  - After collect count reaches L in the same run: ignored (no write), err set.
- Simultaneous events: a data_available on the same cycle as the last rd_en is collected normally.

Test Plan:
- Single element: length=1, A=0x40400000 (3.0), B=0x3F800000 (1.0), unit model latency 23. Required: one data_in_flag cycle at T+3; wr_en at wr_addr 0 with wr_data=0x40800000 (4.0); done pulse one cycle after the write; busy low afterward; err=0.
- Full vector: length=16 with a back-to-back result stream. Required: 16 consecutive data_in_flag cycles; 16 writes to addresses 0..15 in order; exactly one done; err=0.
- Zero and clamp:
  - length=0: done two cycles after start; no rd_en, no wr_en.
  - length=20: exactly 16 reads and 16 writes.
- Timeout: length=4, unit model drops the last result. Required: 3 writes, then after 32 idle DRAIN cycles err=1 and done=1; the next start clears err.
- Ignored inputs:
  - start pulsed during ISSUE: no restart, read count unchanged.
  - data_available while IDLE: no wr_en, err=1.
- Reset mid-run: aclr asserted during ISSUE at element 5. Required: all outputs go to 0 immediately and the FSM is IDLE; a subsequent start with length=3 completes cleanly with 3 writes.
